// File: rtl/irq_ctrl_pkg.sv
// Shared register map, constants and small helpers for the interrupt controller.
package irq_ctrl_pkg;

  localparam logic [3:0] ADDR_ENABLE_LO  = 4'd0;
  localparam logic [3:0] ADDR_ENABLE_HI  = 4'd1;
  localparam logic [3:0] ADDR_MODE_LO    = 4'd2;
  localparam logic [3:0] ADDR_MODE_HI    = 4'd3;
  localparam logic [3:0] ADDR_POL_LO     = 4'd4;
  localparam logic [3:0] ADDR_POL_HI     = 4'd5;
  localparam logic [3:0] ADDR_PENDING_LO = 4'd6;
  localparam logic [3:0] ADDR_PENDING_HI = 4'd7;
  localparam logic [3:0] ADDR_STEP       = 4'd8;
  localparam logic [3:0] ADDR_VECTOR     = 4'd9;

  localparam logic [7:0] VECTOR_NONE = 8'h80;

  typedef logic [15:0] src_vec_t;

  // Lowest-numbered active source wins; VECTOR_NONE when nothing is active.
  function automatic logic [7:0] vector_of(input src_vec_t act);
    logic [7:0] v;
    v = VECTOR_NONE;
    for (int i = 15; i >= 0; i--) begin
      if (act[i]) v = {3'b000, 5'(i)};
    end
    return v;
  endfunction

  function automatic logic [7:0] step_status(input logic pend, input logic counting);
    return {pend, counting, 6'b000000};
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU register bus of the interrupt controller: address, write data, strobe, read data.
interface irq_ctrl_if;
  logic [3:0] a;
  logic [7:0] d;
  logic       we;
  logic [7:0] q;

  modport master (output a, output d, output we, input q);
  modport slave  (input a, input d, input we, output q);
endinterface

// File: rtl/irq_src_cell.sv
// One interrupt source bit: edge history, pending flag and write-one-to-clear.
module irq_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic edge_mode,
  input  logic s,
  input  logic w1c,
  output logic pend
);

  logic hist_reg;
  logic pend_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_reg <= 1'b0;
      pend_reg <= 1'b0;
    end else begin
      hist_reg <= s;
      // A fresh edge beats a same-cycle clear; level sources ignore clears.
      if (edge_mode) pend_reg <= (s & ~hist_reg) | (pend_reg & ~w1c);
      else           pend_reg <= s;
    end
  end

  assign pend = pend_reg;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source enable/mode/polarity, pending with W1C,
// lowest-index vector, and a single-step countdown that raises its own request.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC    = 8,
  parameter int STEPDLY = 23
) (
  input  logic            clk,
  input  logic            reset,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] src,
  output logic            irq
);

  localparam int       CW       = $clog2(STEPDLY + 1);
  localparam src_vec_t SRC_MASK = 16'((32'd1 << NSRC) - 32'd1);

  src_vec_t enable_reg;
  src_vec_t mode_reg;
  src_vec_t pol_reg;
  src_vec_t pending;
  src_vec_t w1c;

  logic [CW-1:0] cnt_reg;
  logic          counting_reg;
  logic          step_pend_reg;
  logic          irq_reg;

  logic step_wr;
  logic step_fire;

  assign step_wr   = bus.we && (bus.a == ADDR_STEP);
  assign step_fire = counting_reg && (cnt_reg == '0);

  always_comb begin
    w1c = '0;
    if (bus.we && bus.a == ADDR_PENDING_LO) w1c[7:0]  = bus.d;
    if (bus.we && bus.a == ADDR_PENDING_HI) w1c[15:8] = bus.d;
  end

  // Unimplemented source positions are tied off so every bus view reads 0 there.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_src
      if (gi < NSRC) begin : g_cell
        irq_src_cell u_cell (
          .clk       (clk),
          .reset     (reset),
          .edge_mode (mode_reg[gi]),
          .s         (src[gi] ^ pol_reg[gi]),
          .w1c       (w1c[gi]),
          .pend      (pending[gi])
        );
      end else begin : g_tie
        assign pending[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_reg <= '0;
      mode_reg   <= '0;
      pol_reg    <= '0;
    end else if (bus.we) begin
      case (bus.a)
        ADDR_ENABLE_LO: enable_reg[7:0]  <= bus.d & SRC_MASK[7:0];
        ADDR_ENABLE_HI: enable_reg[15:8] <= bus.d & SRC_MASK[15:8];
        ADDR_MODE_LO:   mode_reg[7:0]    <= bus.d & SRC_MASK[7:0];
        ADDR_MODE_HI:   mode_reg[15:8]   <= bus.d & SRC_MASK[15:8];
        ADDR_POL_LO:    pol_reg[7:0]     <= bus.d & SRC_MASK[7:0];
        ADDR_POL_HI:    pol_reg[15:8]    <= bus.d & SRC_MASK[15:8];
        default: ;
      endcase
    end
  end

  // A reload on the same edge the count expires still delivers the expiring step.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      counting_reg  <= 1'b0;
      step_pend_reg <= 1'b0;
    end else begin
      step_pend_reg <= step_fire | (step_pend_reg & ~(step_wr & bus.d[7]));
      if (step_wr && bus.d[0]) begin
        cnt_reg      <= CW'(STEPDLY);
        counting_reg <= 1'b1;
      end else if (step_fire) begin
        counting_reg <= 1'b0;
      end else if (counting_reg) begin
        cnt_reg <= cnt_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) irq_reg <= 1'b0;
    else       irq_reg <= (|(pending & enable_reg)) | step_pend_reg;
  end

  assign irq = irq_reg;

  always_comb begin
    case (bus.a)
      ADDR_ENABLE_LO:  bus.q = enable_reg[7:0];
      ADDR_ENABLE_HI:  bus.q = enable_reg[15:8];
      ADDR_MODE_LO:    bus.q = mode_reg[7:0];
      ADDR_MODE_HI:    bus.q = mode_reg[15:8];
      ADDR_POL_LO:     bus.q = pol_reg[7:0];
      ADDR_POL_HI:     bus.q = pol_reg[15:8];
      ADDR_PENDING_LO: bus.q = pending[7:0];
      ADDR_PENDING_HI: bus.q = pending[15:8];
      ADDR_STEP:       bus.q = step_status(step_pend_reg, counting_reg);
      ADDR_VECTOR:     bus.q = vector_of(pending & enable_reg);
      default:         bus.q = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios then random traffic, checked
// every cycle against a behavioural model of the register/interrupt rules.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NSRC    = 12;
  localparam int STEPDLY = 23;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src;
  logic            irq;

  irq_ctrl_if bus ();

  irq_ctrl #(.NSRC(NSRC), .STEPDLY(STEPDLY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .src   (src),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: whole-register bit vectors plus an absolute step deadline.
  bit [15:0] m_en, m_mode, m_pol, m_pend, m_prev;
  bit        m_step, m_counting, m_irq;
  int        m_edge, m_deadline;

  typedef struct {
    int         n;
    logic [3:0] a;
    logic [7:0] q;
    logic       irq;
  } exp_t;

  exp_t sb_q[$];
  int   txn      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic bit [15:0] src_mask();
    bit [15:0] m;
    m = '0;
    for (int i = 0; i < NSRC; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] model_read(input logic [3:0] aa);
    bit [15:0] act;
    logic [7:0] v;
    act = m_pend & m_en;
    case (aa)
      4'd0: v = m_en[7:0];
      4'd1: v = m_en[15:8];
      4'd2: v = m_mode[7:0];
      4'd3: v = m_mode[15:8];
      4'd4: v = m_pol[7:0];
      4'd5: v = m_pol[15:8];
      4'd6: v = m_pend[7:0];
      4'd7: v = m_pend[15:8];
      4'd8: v = {m_step, m_counting, 6'd0};
      4'd9: begin
        v = 8'h80;
        for (int i = 0; i < 16; i++) begin
          if (act[i] && v == 8'h80) v = 8'(i);
        end
      end
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic void model_edge(input bit r, input logic [3:0] aa, input logic [7:0] dd,
                                     input bit w, input logic [NSRC-1:0] ss);
    bit [15:0] w1c, pnew, prevnew, mask;
    bit        s, fire, stepwr, step_new;
    m_edge++;
    if (r) begin
      m_en = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_prev = '0;
      m_step = 0; m_counting = 0; m_irq = 0;
      return;
    end
    mask = src_mask();
    w1c  = '0;
    if (w && aa == 4'd6) w1c[7:0]  = dd;
    if (w && aa == 4'd7) w1c[15:8] = dd;
    pnew    = '0;
    prevnew = '0;
    for (int i = 0; i < NSRC; i++) begin
      s = ss[i] ^ m_pol[i];
      if (m_mode[i]) pnew[i] = (s && !m_prev[i]) || (m_pend[i] && !w1c[i]);
      else           pnew[i] = s;
      prevnew[i] = s;
    end
    m_irq    = ((m_pend & m_en) != 0) || m_step;
    fire     = m_counting && (m_edge == m_deadline);
    stepwr   = w && aa == 4'd8;
    step_new = fire || (m_step && !(stepwr && dd[7]));
    if (stepwr && dd[0]) begin
      m_counting = 1;
      m_deadline = m_edge + STEPDLY + 1;
    end else if (fire) begin
      m_counting = 0;
    end
    m_step = step_new;
    m_pend = pnew;
    m_prev = prevnew;
    if (w) begin
      case (aa)
        4'd0: m_en[7:0]    = dd & mask[7:0];
        4'd1: m_en[15:8]   = dd & mask[15:8];
        4'd2: m_mode[7:0]  = dd & mask[7:0];
        4'd3: m_mode[15:8] = dd & mask[15:8];
        4'd4: m_pol[7:0]   = dd & mask[7:0];
        4'd5: m_pol[15:8]  = dd & mask[15:8];
        default: ;
      endcase
    end
  endfunction

  // One bus cycle: drive inputs, queue what the DUT must show this cycle, advance the model.
  task automatic cyc(input bit r, input logic [3:0] aa, input logic [7:0] dd, input bit w,
                     input logic [NSRC-1:0] ss);
    exp_t e;
    reset  = r;
    bus.a  = aa;
    bus.d  = dd;
    bus.we = w;
    src    = ss;
    e.n    = txn;
    e.a    = aa;
    e.q    = model_read(aa);
    e.irq  = m_irq;
    txn++;
    sb_q.push_back(e);
    @(posedge clk);
    model_edge(r, aa, dd, w, ss);
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] aa, input logic [NSRC-1:0] ss);
    for (int k = 0; k < n; k++) cyc(1'b0, aa, 8'h00, 1'b0, ss);
  endtask

  task automatic wr(input logic [3:0] aa, input logic [7:0] dd, input logic [NSRC-1:0] ss);
    cyc(1'b0, aa, dd, 1'b1, ss);
  endtask

  exp_t got;
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        got = sb_q.pop_front();
        n_checks++;
        if (bus.q === got.q) n_pass++;
        else $display("FAIL q txn=%0d a=%0d got=%h want=%h", got.n, got.a, bus.q, got.q);
        n_checks++;
        if (irq === got.irq) n_pass++;
        else $display("FAIL irq txn=%0d a=%0d got=%b want=%b", got.n, got.a, irq, got.irq);
        $display("txn %0d a=%0d q=%h irq=%b", got.n, got.a, bus.q, irq);
      end
    end
  end

  logic [NSRC-1:0] sv;
  logic [31:0]     r32;
  logic [7:0]      rd;
  logic [3:0]      ra;

  initial begin
    reset  = 1'b1;
    bus.a  = '0;
    bus.d  = '0;
    bus.we = 1'b0;
    src    = '0;
    m_en = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_prev = '0;
    m_step = 0; m_counting = 0; m_irq = 0; m_edge = 0; m_deadline = 0;
    repeat (2) @(posedge clk);
    #1;
    sv = '0;

    for (int i = 0; i < 16; i++) idle(1, 4'(i), sv);

    // Edge source 0, then clear it.
    wr(4'd0, 8'h01, sv);
    wr(4'd2, 8'h01, sv);
    idle(2, 4'd6, sv);
    sv[0] = 1'b1;
    idle(4, 4'd6, sv);
    wr(4'd6, 8'h01, sv);
    idle(3, 4'd9, sv);

    // Fresh edge colliding with a clear of the same bit.
    sv[0] = 1'b0; idle(2, 4'd6, sv);
    sv[0] = 1'b1; idle(2, 4'd6, sv);
    sv[0] = 1'b0; idle(1, 4'd6, sv);
    sv[0] = 1'b1; wr(4'd6, 8'h01, sv);
    idle(3, 4'd6, sv);

    // Active-low level source 3.
    wr(4'd4, 8'h08, sv);
    wr(4'd0, 8'h08, sv);
    sv[3] = 1'b1; idle(3, 4'd6, sv);
    sv[3] = 1'b0; idle(3, 4'd6, sv);
    wr(4'd6, 8'h08, sv);
    idle(2, 4'd6, sv);
    sv[3] = 1'b1; idle(3, 4'd6, sv);

    // Vector priority between sources 2 and 5.
    wr(4'd4, 8'h00, sv);
    wr(4'd2, 8'h24, sv);
    wr(4'd0, 8'h24, sv);
    sv = '0; idle(2, 4'd9, sv);
    sv[5] = 1'b1; sv[2] = 1'b1;
    idle(3, 4'd9, sv);
    wr(4'd6, 8'h04, sv); idle(2, 4'd9, sv);
    wr(4'd6, 8'h20, sv); idle(2, 4'd9, sv);

    // Single-step countdown, restart, then clear.
    wr(4'd8, 8'h01, sv);
    idle(9, 4'd8, sv);
    wr(4'd8, 8'h01, sv);
    idle(30, 4'd8, sv);
    wr(4'd8, 8'h80, sv);
    idle(3, 4'd8, sv);

    // Upper byte masking beyond NSRC.
    wr(4'd1, 8'hFF, sv);
    wr(4'd3, 8'hFF, sv);
    wr(4'd5, 8'hFF, sv);
    idle(1, 4'd1, sv); idle(1, 4'd3, sv); idle(1, 4'd5, sv); idle(1, 4'd7, sv);

    // Reset in the middle of a countdown; no step may appear afterwards.
    wr(4'd8, 8'h01, sv);
    idle(5, 4'd8, sv);
    cyc(1'b1, 4'd8, 8'h00, 1'b0, sv);
    sv = '0;
    for (int i = 0; i < 16; i++) idle(1, 4'(i), sv);
    idle(30, 4'd8, sv);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        r32 = $urandom();
        sv  = sv ^ r32[NSRC-1:0];
      end
      ra = 4'($urandom_range(0, 15));
      rd = 8'($urandom());
      if (ra == 4'd8 && $urandom_range(0, 3) != 0) rd[0] = 1'b0;
      cyc($urandom_range(0, 299) == 0, ra, rd, $urandom_range(0, 2) == 0, sv);
    end

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain left=%0d want=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
